// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 host-to-device transmitter: FSM states,
// error codes and the mouse command bytes.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    INHIBIT   = 3'd1,
    REQ       = 3'd2,
    SEND      = 3'd3,
    WAIT_IDLE = 3'd4
  } ps2_state_e;

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_START_TO = 2'b01;
  localparam logic [1:0] ERR_XFER_TO  = 2'b10;
  localparam logic [1:0] ERR_NO_ACK   = 2'b11;

  localparam logic [7:0] CMD_RESET    = 8'hFF;
  localparam logic [7:0] CMD_ENABLE   = 8'hF4;
  localparam logic [7:0] CMD_SET_RATE = 8'hF3;
  localparam logic [7:0] ACK_BYTE     = 8'hFA;

  // PS/2 frames carry odd parity: data bits plus parity hold an odd number of ones
  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Conditions one raw PS/2 line: 2-FF synchronizer, stability filter that needs
// FILTER_LEN consecutive differing samples to move, and a falling-edge pulse.
module ps2_line_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic line_in,
  output logic level,
  output logic fall_edge
);

  localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  logic [1:0]    sync_r;
  logic [CW-1:0] stable_cnt_r;
  logic          level_r;
  logic          fall_r;

  // two-stage synchronizer; idle bus level is high
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_r <= 2'b11;
    end else begin
      sync_r <= {sync_r[0], line_in};
    end
  end

  // stability filter; fall_r is high in the first cycle the level reads low
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stable_cnt_r <= '0;
      level_r      <= 1'b1;
      fall_r       <= 1'b0;
    end else if (sync_r[1] == level_r) begin
      stable_cnt_r <= '0;
      fall_r       <= 1'b0;
    end else if (stable_cnt_r == CW'(FILTER_LEN - 1)) begin
      stable_cnt_r <= '0;
      level_r      <= sync_r[1];
      fall_r       <= level_r;
    end else begin
      stable_cnt_r <= stable_cnt_r + CW'(1);
      fall_r       <= 1'b0;
    end
  end

  assign level     = level_r;
  assign fall_edge = fall_r;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, clock out one
// command byte with odd parity and stop bit, then check the device ack.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYC       = 13000,
  parameter int RTS_SETUP_CYC     = 260,
  parameter int START_TIMEOUT_CYC = 1950000,
  parameter int XFER_TIMEOUT_CYC  = 260000,
  parameter int FILTER_LEN        = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_drive_low,
  output logic       ps2_data_drive_low,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [1:0] err_code
);

  localparam int MAX_AB  = (INHIBIT_CYC > RTS_SETUP_CYC) ? INHIBIT_CYC : RTS_SETUP_CYC;
  localparam int MAX_CD  = (START_TIMEOUT_CYC > XFER_TIMEOUT_CYC) ? START_TIMEOUT_CYC : XFER_TIMEOUT_CYC;
  localparam int MAX_CYC = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int CW      = $clog2(MAX_CYC + 1);

  ps2_state_e    state_r, state_s;
  logic [CW-1:0] cnt_r, cnt_s;
  logic [3:0]    bit_cnt_r, bit_cnt_s;
  logic [7:0]    data_r, data_s;
  logic          parity_r, parity_s;
  logic          clk_dl_r, clk_dl_s;
  logic          data_dl_r, data_dl_s;
  logic [1:0]    err_code_r, err_code_s;
  logic          done_r, done_s;
  logic          error_r, error_s;
  logic          tx_ready_r, busy_r;
  logic          abort_s;
  logic [1:0]    abort_code_s;
  logic          clk_lvl_s, clk_fall_s, data_lvl_s, data_fall_unused_s;

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
    .clk(clk), .rst(rst), .line_in(ps2_clk_in),
    .level(clk_lvl_s), .fall_edge(clk_fall_s)
  );

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filter (
    .clk(clk), .rst(rst), .line_in(ps2_data_in),
    .level(data_lvl_s), .fall_edge(data_fall_unused_s)
  );

  // next state, counters and next values of the registered outputs
  always_comb begin
    state_s      = state_r;
    cnt_s        = cnt_r + CW'(1);
    bit_cnt_s    = bit_cnt_r;
    data_s       = data_r;
    parity_s     = parity_r;
    clk_dl_s     = clk_dl_r;
    data_dl_s    = data_dl_r;
    err_code_s   = err_code_r;
    done_s       = 1'b0;
    error_s      = 1'b0;
    abort_s      = 1'b0;
    abort_code_s = ERR_NONE;
    case (state_r)
      IDLE: begin
        cnt_s     = '0;
        bit_cnt_s = 4'd0;
        clk_dl_s  = 1'b0;
        data_dl_s = 1'b0;
        if (tx_valid && tx_ready_r) begin
          state_s    = INHIBIT;
          data_s     = tx_data;
          parity_s   = odd_parity(tx_data);
          err_code_s = ERR_NONE;
          clk_dl_s   = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      INHIBIT: begin
        if (cnt_r == CW'(INHIBIT_CYC - 1)) begin
          state_s   = REQ;
          cnt_s     = '0;
          data_dl_s = 1'b1;
        end else begin
          state_s = INHIBIT;
        end
      end
      REQ: begin
        if (cnt_r == CW'(RTS_SETUP_CYC - 1)) begin
          state_s   = SEND;
          cnt_s     = '0;
          clk_dl_s  = 1'b0;
        end else begin
          state_s = REQ;
        end
      end
      SEND: begin
        // a falling edge takes priority over a timeout expiring in the same cycle
        if (clk_fall_s) begin
          bit_cnt_s = bit_cnt_r + 4'd1;
          cnt_s     = (bit_cnt_r == 4'd0) ? '0 : cnt_r + CW'(1);
          if (bit_cnt_r < 4'd8) begin
            data_dl_s = ~data_r[bit_cnt_r[2:0]];
          end else if (bit_cnt_r == 4'd8) begin
            data_dl_s = ~parity_r;
          end else if (bit_cnt_r == 4'd9) begin
            data_dl_s = 1'b0;
          end else if (data_lvl_s) begin
            abort_s      = 1'b1;
            abort_code_s = ERR_NO_ACK;
          end else begin
            state_s = WAIT_IDLE;
          end
        end else if (bit_cnt_r == 4'd0) begin
          if (cnt_r == CW'(START_TIMEOUT_CYC - 1)) begin
            abort_s      = 1'b1;
            abort_code_s = ERR_START_TO;
          end else begin
            state_s = SEND;
          end
        end else begin
          if (cnt_r == CW'(XFER_TIMEOUT_CYC - 1)) begin
            abort_s      = 1'b1;
            abort_code_s = ERR_XFER_TO;
          end else begin
            state_s = SEND;
          end
        end
      end
      WAIT_IDLE: begin
        cnt_s     = '0;
        clk_dl_s  = 1'b0;
        data_dl_s = 1'b0;
        if (clk_lvl_s && data_lvl_s) begin
          state_s = IDLE;
          done_s  = 1'b1;
        end else begin
          state_s = WAIT_IDLE;
        end
      end
      default: begin
        state_s   = IDLE;
        clk_dl_s  = 1'b0;
        data_dl_s = 1'b0;
      end
    endcase
    if (abort_s) begin
      state_s    = IDLE;
      clk_dl_s   = 1'b0;
      data_dl_s  = 1'b0;
      err_code_s = abort_code_s;
      error_s    = 1'b1;
    end else begin
      error_s = 1'b0;
    end
  end

  // state and registered outputs; reset releases both lines immediately
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= IDLE;
      cnt_r      <= '0;
      bit_cnt_r  <= 4'd0;
      data_r     <= 8'h00;
      parity_r   <= 1'b0;
      clk_dl_r   <= 1'b0;
      data_dl_r  <= 1'b0;
      err_code_r <= ERR_NONE;
      done_r     <= 1'b0;
      error_r    <= 1'b0;
      tx_ready_r <= 1'b1;
      busy_r     <= 1'b0;
    end else begin
      state_r    <= state_s;
      cnt_r      <= cnt_s;
      bit_cnt_r  <= bit_cnt_s;
      data_r     <= data_s;
      parity_r   <= parity_s;
      clk_dl_r   <= clk_dl_s;
      data_dl_r  <= data_dl_s;
      err_code_r <= err_code_s;
      done_r     <= done_s;
      error_r    <= error_s;
      tx_ready_r <= (state_s == IDLE);
      busy_r     <= (state_s != IDLE);
    end
  end

  assign tx_ready           = tx_ready_r;
  assign busy               = busy_r;
  assign ps2_clk_drive_low  = clk_dl_r;
  assign ps2_data_drive_low = data_dl_r;
  assign done               = done_r;
  assign error              = error_r;
  assign err_code           = err_code_r;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a behavioural PS/2 device clocks frames out of the
// host and compares every bit and status against a frame model.
module tb_ps2_host_tx;
  import ps2_pkg::*;

  localparam int INH = 200;
  localparam int RTS = 20;
  localparam int STO = 1000;
  localparam int XTO = 5000;
  localparam int FL  = 8;

  localparam int M_OK = 0, M_NOACK = 1, M_STALL = 2, M_GLITCH = 3, M_RST = 4, M_SILENT = 5;

  logic       clk, rst;
  logic [7:0] tx_data;
  logic       tx_valid, tx_ready;
  logic       ps2_clk_in, ps2_data_in;
  logic       ps2_clk_drive_low, ps2_data_drive_low;
  logic       busy, done, error;
  logic [1:0] err_code;
  logic       dev_clk_low, dev_data_low;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int done_cnt = 0;
  int err_cnt = 0;

  // open-drain bus: either side pulling low wins
  assign ps2_clk_in  = ~(ps2_clk_drive_low | dev_clk_low);
  assign ps2_data_in = ~(ps2_data_drive_low | dev_data_low);

  ps2_host_tx #(
    .INHIBIT_CYC(INH), .RTS_SETUP_CYC(RTS), .START_TIMEOUT_CYC(STO),
    .XFER_TIMEOUT_CYC(XTO), .FILTER_LEN(FL)
  ) dut (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .ps2_clk_in(ps2_clk_in), .ps2_data_in(ps2_data_in),
    .ps2_clk_drive_low(ps2_clk_drive_low), .ps2_data_drive_low(ps2_data_drive_low),
    .busy(busy), .done(done), .error(error), .err_code(err_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (done)  done_cnt <= done_cnt + 1;
    if (error) err_cnt  <= err_cnt + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // expected data line level read by the device after falling edge k (1..10)
  function automatic logic exp_level(input logic [7:0] b, input int k);
    int v, ones;
    v = int'(b);
    ones = 0;
    for (int i = 0; i < 8; i++) ones += (v >> i) % 2;
    if (k <= 8) return ((v >> (k - 1)) % 2) == 1;
    if (k == 9) return (ones % 2) == 0;
    return 1'b1;
  endfunction

  task automatic run_frame(input logic [7:0] b, input int mode, input int half);
    int n, dn0, er0, e1;
    n = 0;
    while (!tx_ready && n < 2000) begin tick(); n++; end
    chk("ready_before_accept", tx_ready, 1'b1);
    tx_data  = b;
    tx_valid = 1'b1;
    tick();
    dn0 = done_cnt;
    er0 = err_cnt;
    // a new request while busy must be ignored
    tx_data = ~b;
    chk("accept_state", {busy, tx_ready, ps2_clk_drive_low, ps2_data_drive_low}, 4'b1010);
    chk("accept_err_clear", err_code, ERR_NONE);
    n = 0;
    while (!ps2_data_drive_low && n < INH + 50) begin tick(); n++; end
    tx_valid = 1'b0;
    chk("inhibit_len", n, INH);
    chk("req_clk_low", ps2_clk_drive_low, 1'b1);
    n = 0;
    while (ps2_clk_drive_low && n < RTS + 50) begin tick(); n++; end
    chk("rts_len", n, RTS);
    chk("start_bit_held", ps2_data_drive_low, 1'b1);
    if (mode == M_SILENT) begin
      n = 0;
      while (!error && n < STO + 100) begin tick(); n++; end
      chk("start_to_len", n, STO);
      chk("start_to_code", err_code, ERR_START_TO);
      chk("start_to_release", {ps2_clk_drive_low, ps2_data_drive_low, tx_ready}, 3'b001);
      return;
    end
    repeat (half) tick();
    e1 = cyc;
    for (int k = 1; k <= 11; k++) begin
      if (k == 1) chk("start_bit", ps2_data_in, 1'b0);
      dev_clk_low = 1'b1;
      if (k == 1) e1 = cyc;
      repeat (half) tick();
      dev_clk_low = 1'b0;
      if (k <= 10) chk($sformatf("bit%0d_b%02h", k, b), ps2_data_in, exp_level(b, k));
      if (mode == M_RST && k == 4) begin
        #2 rst = 1'b1;
        #1;
        chk("rst_release", {ps2_clk_drive_low, ps2_data_drive_low}, 2'b00);
        chk("rst_status", {tx_ready, busy, done, error, err_code}, 6'b100000);
        tick();
        rst = 1'b0;
        repeat (20) tick();
        return;
      end
      if (mode == M_STALL && k == 5) begin
        n = 0;
        while (err_cnt == er0 && n < XTO + 200) begin tick(); n++; end
        chk("xfer_to_code", err_code, ERR_XFER_TO);
        chk("xfer_to_window", ((cyc - e1) >= XTO) && ((cyc - e1) <= XTO + 20), 1'b1);
        chk("xfer_to_release", {ps2_clk_drive_low, ps2_data_drive_low, tx_ready}, 3'b001);
        chk("xfer_to_no_done", done_cnt - dn0, 0);
        return;
      end
      if (mode == M_GLITCH && k == 3) begin
        repeat (4) tick();
        dev_clk_low = 1'b1;
        repeat (FL - 1) tick();
        dev_clk_low = 1'b0;
      end
      if (k == 10 && mode != M_NOACK) dev_data_low = 1'b1;
      repeat (half) tick();
    end
    dev_data_low = 1'b0;
    n = 0;
    while (done_cnt == dn0 && err_cnt == er0 && n < 200) begin tick(); n++; end
    if (mode == M_NOACK) begin
      chk("noack_error", err_cnt - er0, 1);
      chk("noack_code", err_code, ERR_NO_ACK);
      chk("noack_no_done", done_cnt - dn0, 0);
    end else begin
      chk("done_pulse", done_cnt - dn0, 1);
      chk("done_no_error", err_cnt - er0, 0);
      chk("done_code", err_code, ERR_NONE);
      tick();
      chk("done_one_cycle", done, 1'b0);
    end
    chk("end_idle", {tx_ready, busy, ps2_clk_drive_low, ps2_data_drive_low}, 4'b1000);
  endtask

  initial begin
    rst          = 1'b1;
    tx_valid     = 1'b0;
    tx_data      = 8'h00;
    dev_clk_low  = 1'b0;
    dev_data_low = 1'b0;
    repeat (3) tick();
    chk("reset_outputs", {tx_ready, busy, ps2_clk_drive_low, ps2_data_drive_low, done, error, err_code},
        8'b1000_0000);
    rst = 1'b0;
    repeat (20) tick();

    run_frame(CMD_ENABLE, M_OK, 40);
    run_frame(8'h00, M_OK, $urandom_range(30, 50));
    // eight ones: the odd-parity bit is 1
    run_frame(CMD_RESET, M_OK, $urandom_range(30, 50));
    run_frame(8'($urandom), M_SILENT, 40);
    repeat (30) tick();
    run_frame(8'($urandom), M_STALL, $urandom_range(30, 50));
    repeat (30) tick();
    run_frame(8'($urandom), M_NOACK, $urandom_range(30, 50));
    repeat (50) tick();
    chk("err_code_held", err_code, ERR_NO_ACK);
    run_frame(8'($urandom), M_OK, $urandom_range(30, 50));
    run_frame(8'($urandom), M_GLITCH, $urandom_range(30, 50));
    run_frame(CMD_SET_RATE, M_RST, $urandom_range(30, 50));
    run_frame(8'($urandom), M_OK, $urandom_range(30, 50));
    for (int i = 0; i < 4; i++) run_frame(8'($urandom), M_OK, $urandom_range(30, 50));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
